// File: rtl/vga_dither_out.sv
// TinyVGA PMOD output stage: 4x4 Bayer dither from 4 to 2 bits per channel, blanking,
// sync delay-matching and a synchronous frame counter derived from vsync.

// One colour channel of stage 2: round q up when the dropped bits beat the threshold.
module vga_dither_lane (
  input  logic [3:0] c,
  input  logic [3:0] t,
  input  logic       den,
  input  logic       de,
  output logic [1:0] q_out
);
  logic [1:0] q;
  logic [3:0] s;

  assign q = c[3:2];
  assign s = {c[1:0], 2'b00};

  always_comb begin
    q_out = 2'd0;
    if (de) begin
      q_out = q;
      // saturate at 3 rather than wrapping to black
      if (den && (s > t) && (q != 2'd3)) q_out = q + 2'd1;
    end
  end
endmodule

module vga_dither_out #(
  parameter bit VS_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       de_in,
  input  logic [1:0] pix_x,
  input  logic [1:0] pix_y,
  input  logic       dither_en,
  input  logic       temporal_en,
  output logic [7:0] uo_out,
  output logic [7:0] frame_cnt,
  output logic       frame_tick
);
  localparam int  NUM_LANES = 3;
  localparam logic VS_IDLE  = VS_ACTIVE_LOW;

  logic [NUM_LANES-1:0][3:0] col_s1;
  logic [NUM_LANES-1:0][1:0] q_s2;
  logic [3:0] thr, thr_s1;
  logic [1:0] x_idx;
  logic       hs_s1, vs_s1, de_s1, den_s1;
  logic       vs_prev, vs_edge;

  // Temporal mode shifts the pattern column by the frame count; old count on edge cycles.
  assign x_idx = pix_x ^ (temporal_en ? frame_cnt[1:0] : 2'b00);

  always_comb begin
    thr = 4'd0;
    case ({pix_y, x_idx})
      4'h0: thr = 4'd0;   4'h1: thr = 4'd8;   4'h2: thr = 4'd2;   4'h3: thr = 4'd10;
      4'h4: thr = 4'd12;  4'h5: thr = 4'd4;   4'h6: thr = 4'd14;  4'h7: thr = 4'd6;
      4'h8: thr = 4'd3;   4'h9: thr = 4'd11;  4'hA: thr = 4'd1;   4'hB: thr = 4'd9;
      4'hC: thr = 4'd15;  4'hD: thr = 4'd7;   4'hE: thr = 4'd13;  4'hF: thr = 4'd5;
      default: thr = 4'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1 <= '0;
      thr_s1 <= '0;
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      de_s1  <= 1'b0;
      den_s1 <= 1'b0;
    end else begin
      col_s1 <= {b_in, g_in, r_in};
      thr_s1 <= thr;
      hs_s1  <= hsync_in;
      vs_s1  <= vsync_in;
      de_s1  <= de_in;
      den_s1 <= dither_en;
    end
  end

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
      vga_dither_lane u_lane (
        .c     (col_s1[l]),
        .t     (thr_s1),
        .den   (den_s1),
        .de    (de_s1),
        .q_out (q_s2[l])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) uo_out <= 8'h00;
    else        uo_out <= {hs_s1, q_s2[2][0], q_s2[1][0], q_s2[0][0],
                           vs_s1, q_s2[2][1], q_s2[1][1], q_s2[0][1]};
  end

  // History resets idle so a vsync held active out of reset still yields one tick.
  assign vs_edge = (vsync_in != VS_IDLE) && (vs_prev == VS_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_prev    <= VS_IDLE;
      frame_tick <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      vs_prev    <= vsync_in;
      frame_tick <= vs_edge;
      if (vs_edge) frame_cnt <= frame_cnt + 8'd1;
    end
  end
endmodule
